ysyx_25020037_idu_queue: RTL
============================

// Module: ysyx_25020037_idu_queue
// PURPOSE
//  Parametrised decode stage: a DEPTH-entry instruction queue between IFU and EXU, with decode of the head entry.
//  Decouples fetch from execute stalls, flushes on redirect, and flags illegal encodings.
//  Head-entry decode is combinational and drives a fixed-layout control bundle.
//  Optional RV32M decode.
// PARAMETERS
//  DEPTH   2   queue entries; power of two, >=2
//  PC_W    32  pc width carried through the queue
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  ifu_valid    in   1      fetch entry valid
//  ifu_ready    out  1      queue can accept (= count<DEPTH)
//  ifu_pc       in   PC_W   fetched pc
//  ifu_inst     in   32     fetched instruction
//  flush        in   1      redirect (exu dnpc valid): drop all entries
//  idu_valid    out  1      head entry valid (= count!=0)
//  exu_ready    in   1      EXU accepts head this cycle
//  idu_pc       out  PC_W   head pc
//  idu_inst     out  32     head instruction
//  idu_imm      out  32     I/S/B/U/J immediate selected by type; 0 for R/N
//  idu_rs       out  15     {rs1,rs2,rd}
//  idu_alu_op   out  25     one-hot op: [0]add [1]sub [2]slt [3]sltu [4]and [5]or [6]xor [7]sll [8]srl [9]sra [10]lui
//                           [11]bne [12]beq [13]bge [14]bgeu [15]blt [16]bltu [17..24]mul,mulh,mulhsu,mulhu,div,divu,rem,remu
//  idu_ctrl     out  16     [0]gpr_we [1]mem_rd [2]mem_wr [5:3]size{w,h,b} [6]load_sext [7]src1_is_pc [8]src2_is_imm
//                           [9]is_jump [10]is_branch [11]ebreak [12]ecall [13]mret [14]csrrw [15]csrrs
//  idu_illegal  out  1      head matches no supported encoding
//  occupancy    out  $clog2(DEPTH+1)  current entry count
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, idu_valid=0, ifu_ready=1; reset mid-operation discards all entries.
//  - enq = ifu_valid&ifu_ready; deq = idu_valid&exu_ready; both on the same cycle leave count unchanged.
//  - ifu_ready depends only on count; a full queue does not accept even when deq fires that cycle.
//  - Latency: an entry enqueued at edge N is visible at idu_valid after N (next cycle); no bypass.
//  - Ptrs wrap mod DEPTH; full = count==DEPTH, empty = count==0.
//  - flush has priority over enq/deq: count and ptrs go to 0 at the edge; the enq in the flush cycle is dropped;
//    idu_valid=0 the next cycle; a deq in the flush cycle is still seen by EXU (EXU handles the redirect).
//  - Outputs while idu_valid=0: idu_alu_op, idu_ctrl, idu_imm, idu_illegal forced 0.
//  - Decode: RV32I base + csrrw/csrrs/ecall/ebreak/mret/fence.i; fence.i is legal, all ctrl 0.
//    add-type ops for addi/auipc/jal/jalr/loads/stores; sltiu->[3]; slli/srli/srai gate on inst[31:26].
//  - load_sext=1 for lb/lh only; size one-hot from lw/lh(u)/lb(u) or sw/sh/sb.
//  - is_jump = jal|jalr|branch|ecall|mret.
//  - gpr_we is forced 0 when rd==0 except csrrw/csrrs (side effects kept).
//  - idu_illegal=1 -> all other ctrl/alu_op bits 0; inst 0x00000000 is legal NOP-halt (N type, all ctrl 0).
// CONFIGURATION
//  IDU_RV32M_EN defined: opcode 0x33 + funct7 0x01 decodes to alu_op[24:17], gpr_we=1.
//  Not defined: alu_op[24:17] tied 0; those encodings raise idu_illegal.
// TESTING
//  - Enq 0x00500093 (addi x1,x0,5), exu_ready=1 -> next cycle idu_valid=1, alu_op[0]=1, imm=5, rs={0,5,1}, ctrl[0]=1, ctrl[8]=1.
//  - DEPTH=2, exu_ready=0, push 3 entries -> ifu_ready=0 after 2nd; occupancy=2; 3rd held, accepted after one deq.
//  - count=2, flush=1 with ifu_valid=1 -> next cycle occupancy=0, idu_valid=0, ifu_ready=1.
//  - 0x022081b3 (mul x3,x1,x2) -> IDU_RV32M_EN: alu_op[17]=1, illegal=0; else illegal=1, alu_op=0.
//  - 0xFFFFFFFF -> idu_illegal=1, ctrl=0; 0xFE208EE3 (beq) -> alu_op[12], ctrl[7,8,9,10]=1, imm=-4.
//  - Steady enq+deq every cycle, 8 instructions -> occupancy stays 1, order preserved across pointer wrap.

Source files
------------

// File: rtl/ysyx_25020037_idu_queue.sv
// Instruction queue between IFU and EXU with combinational decode of the head entry.
// Latency: an entry enqueued at edge N is at the head after N; head decode adds no cycles.
// Backpressure: ifu_ready = (count < DEPTH) only; exu_ready pops the head; flush empties the queue.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ifu_valid/ifu_ready/ifu_pc/ifu_inst   enqueue side
//   flush                            redirect, drops every entry at the edge
//   idu_valid/exu_ready              dequeue handshake
//   idu_pc/idu_inst/idu_imm/idu_rs   head pc, raw instruction, immediate, {rs1,rs2,rd}
//   idu_alu_op/idu_ctrl/idu_illegal  decoded control bundle of the head (0 while empty)
//   occupancy                        current entry count
//
// Optional feature: define IDU_RV32M_EN to decode RV32M (opcode 0x33, funct7 0x01)
// onto idu_alu_op[24:17]; when undefined those encodings are illegal.
module ysyx_25020037_idu_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ifu_valid,
  output logic                         ifu_ready,
  input  logic [PC_W-1:0]              ifu_pc,
  input  logic [31:0]                  ifu_inst,
  input  logic                         flush,
  output logic                         idu_valid,
  input  logic                         exu_ready,
  output logic [PC_W-1:0]              idu_pc,
  output logic [31:0]                  idu_inst,
  output logic [31:0]                  idu_imm,
  output logic [14:0]                  idu_rs,
  output logic [24:0]                  idu_alu_op,
  output logic [15:0]                  idu_ctrl,
  output logic                         idu_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IMM_N, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  // ---------------------------------------------------------------- queue
  logic [PC_W-1:0]  pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             full, empty, enq, deq;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign ifu_ready = ~full;
  assign idu_valid = ~empty;
  assign enq       = ifu_valid & ifu_ready;
  assign deq       = idu_valid & exu_ready;
  assign occupancy = count;

  // Pointers rely on DEPTH being a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the flush-cycle enqueue is dropped.
  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) begin
      pc_mem[wr_ptr]   <= ifu_pc;
      inst_mem[wr_ptr] <= ifu_inst;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [31:0] inst;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;

  assign inst     = inst_mem[rd_ptr];
  assign idu_pc   = pc_mem[rd_ptr];
  assign idu_inst = inst;
  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rd       = inst[11:7];
  assign idu_rs   = {inst[19:15], inst[24:20], inst[11:7]};

  imm_t        imm_sel;
  logic        legal, we, is_csr;
  logic [24:0] alu;
  logic [15:1] ctrl_hi;

  always_comb begin
    imm_sel = IMM_N;
    legal   = 1'b0;
    we      = 1'b0;
    is_csr  = 1'b0;
    alu     = '0;
    ctrl_hi = '0;
    case (opc)
      7'h37: begin  // lui
        legal = 1'b1; we = 1'b1; alu[10] = 1'b1; ctrl_hi[8] = 1'b1; imm_sel = IMM_U;
      end
      7'h17: begin  // auipc
        legal = 1'b1; we = 1'b1; alu[0] = 1'b1; ctrl_hi[8:7] = 2'b11; imm_sel = IMM_U;
      end
      7'h6f: begin  // jal
        legal = 1'b1; we = 1'b1; alu[0] = 1'b1; ctrl_hi[9:7] = 3'b111; imm_sel = IMM_J;
      end
      7'h67: begin  // jalr
        if (f3 == 3'd0) begin
          legal = 1'b1; we = 1'b1; alu[0] = 1'b1; ctrl_hi[9:8] = 2'b11; imm_sel = IMM_I;
        end
      end
      7'h63: begin  // branches: pc-relative target, compare op selects condition
        legal = 1'b1; ctrl_hi[10:7] = 4'b1111; imm_sel = IMM_B;
        case (f3)
          3'd0:    alu[12] = 1'b1;
          3'd1:    alu[11] = 1'b1;
          3'd4:    alu[15] = 1'b1;
          3'd5:    alu[13] = 1'b1;
          3'd6:    alu[16] = 1'b1;
          3'd7:    alu[14] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      7'h03: begin  // loads
        legal = 1'b1; we = 1'b1; alu[0] = 1'b1; ctrl_hi[1] = 1'b1; ctrl_hi[8] = 1'b1; imm_sel = IMM_I;
        case (f3)
          3'd0:    begin ctrl_hi[3] = 1'b1; ctrl_hi[6] = 1'b1; end
          3'd1:    begin ctrl_hi[4] = 1'b1; ctrl_hi[6] = 1'b1; end
          3'd2:    ctrl_hi[5] = 1'b1;
          3'd4:    ctrl_hi[3] = 1'b1;
          3'd5:    ctrl_hi[4] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      7'h23: begin  // stores
        legal = 1'b1; alu[0] = 1'b1; ctrl_hi[2] = 1'b1; ctrl_hi[8] = 1'b1; imm_sel = IMM_S;
        case (f3)
          3'd0:    ctrl_hi[3] = 1'b1;
          3'd1:    ctrl_hi[4] = 1'b1;
          3'd2:    ctrl_hi[5] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      7'h13: begin  // op-imm; shifts check inst[31:26], inst[25] is ignored
        legal = 1'b1; we = 1'b1; ctrl_hi[8] = 1'b1; imm_sel = IMM_I;
        case (f3)
          3'd0: alu[0] = 1'b1;
          3'd2: alu[2] = 1'b1;
          3'd3: alu[3] = 1'b1;
          3'd4: alu[6] = 1'b1;
          3'd6: alu[5] = 1'b1;
          3'd7: alu[4] = 1'b1;
          3'd1: if (f7[6:1] == 6'h00) alu[7] = 1'b1; else legal = 1'b0;
          default: begin
            if (f7[6:1] == 6'h00)      alu[8] = 1'b1;
            else if (f7[6:1] == 6'h10) alu[9] = 1'b1;
            else                       legal  = 1'b0;
          end
        endcase
      end
      7'h33: begin  // register-register
        we = 1'b1;
        if (f7 == 7'h00) begin
          legal = 1'b1;
          case (f3)
            3'd0:    alu[0] = 1'b1;
            3'd1:    alu[7] = 1'b1;
            3'd2:    alu[2] = 1'b1;
            3'd3:    alu[3] = 1'b1;
            3'd4:    alu[6] = 1'b1;
            3'd5:    alu[8] = 1'b1;
            3'd6:    alu[5] = 1'b1;
            default: alu[4] = 1'b1;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0)      begin legal = 1'b1; alu[1] = 1'b1; end
          else if (f3 == 3'd5) begin legal = 1'b1; alu[9] = 1'b1; end
        end
`ifdef IDU_RV32M_EN
        else if (f7 == 7'h01) begin
          // funct3 order matches alu_op[24:17]: mul..remu
          legal      = 1'b1;
          alu[24:17] = 8'd1 << f3;
        end
`endif
      end
      7'h73: begin  // system
        case (f3)
          3'd0: begin
            if (inst == 32'h0000_0073)      begin legal = 1'b1; ctrl_hi[12] = 1'b1; ctrl_hi[9] = 1'b1; end
            else if (inst == 32'h0010_0073) begin legal = 1'b1; ctrl_hi[11] = 1'b1; end
            else if (inst == 32'h3020_0073) begin legal = 1'b1; ctrl_hi[13] = 1'b1; ctrl_hi[9] = 1'b1; end
          end
          3'd1: begin legal = 1'b1; we = 1'b1; is_csr = 1'b1; ctrl_hi[14] = 1'b1; imm_sel = IMM_I; end
          3'd2: begin legal = 1'b1; we = 1'b1; is_csr = 1'b1; ctrl_hi[15] = 1'b1; imm_sel = IMM_I; end
          default: ;
        endcase
      end
      7'h0f: begin  // fence / fence.i: legal, no control effect
        if (f3 == 3'd0 || f3 == 3'd1) legal = 1'b1;
      end
      7'h00: begin  // all-zero word is a legal halt/NOP
        if (inst == 32'h0) legal = 1'b1;
      end
      default: ;
    endcase
  end

  logic        dec_ok, gpr_we;
  logic [31:0] imm;

  // CSR ops keep their write even to x0 so the read side effect is preserved.
  assign gpr_we = we & ((rd != 5'd0) | is_csr);

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  assign dec_ok      = idu_valid & legal;
  assign idu_illegal = idu_valid & ~legal;
  assign idu_alu_op  = dec_ok ? alu : '0;
  assign idu_ctrl    = dec_ok ? {ctrl_hi, gpr_we} : '0;
  assign idu_imm     = dec_ok ? imm : '0;

endmodule
